// File: rtl/vga_pkg.sv
// VGA timing constants, grid geometry helpers and the {R,G,B} pixel type
// shared by the grid renderer and its sub-modules.
// Contents: rgb_t, H/V totals, active-area bounds, commit line, NUM_CELLS, cell_index().
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;

  localparam logic [9:0] H_ACT_START = 10'd144;
  localparam logic [9:0] H_ACT_END   = 10'd783;
  localparam logic [9:0] V_ACT_START = 10'd35;
  localparam logic [9:0] V_ACT_END   = 10'd514;

  // First blanking line after the active area: the bank swap happens here.
  localparam logic [9:0] COMMIT_LINE = 10'd515;

  localparam int NUM_CELLS = 9;
  localparam int GRID_DIM  = 3;

  // Row-major cell number from grid coordinates.
  function automatic logic [3:0] cell_index(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep sync signals aligned with the pixel pipeline.
// Ports: clk_25Mhz/rst (async, active-high, clears every tap), din in, dout = din delayed DEPTH cycles.
// Parameters: WIDTH bits per tap, DEPTH taps (>= 1).
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_25Mhz,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/grid_cell_renderer.sv
// Draws a 3x3 grid of solid-colour cells on a 640x480 VGA frame, 2-cycle pixel pipeline;
// cell colours are written into a pending bank and swapped into the displayed bank at line 515.
// Ports: clk_25Mhz/rst, hcount/vcount/hsync_in/vsync_in in, Red/Green/Blue/hsync_out/vsync_out out,
//        wr_valid/wr_ready/wr_cell/wr_color write port, frame_commit pulse, sticky bad_cell.
// Optional: define GRID_BORDER_EN to draw a 2-pixel black ring on the inside edge of every cell.
// Geometry must satisfy 3*CELL_W+2*GAP_X <= 640 and 3*CELL_H+2*GAP_Y <= 480.
module grid_cell_renderer
  import vga_pkg::*;
#(
  parameter int          CELL_W   = 160,
  parameter int          CELL_H   = 120,
  parameter int          GAP_X    = 80,
  parameter int          GAP_Y    = 60,
  parameter logic [23:0] BG_COLOR = 24'hFFFFFF
) (
  input  logic        clk_25Mhz,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_cell,
  input  logic [23:0] wr_color,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_commit,
  output logic        bad_cell
);

  localparam logic [9:0] CW      = 10'(CELL_W);
  localparam logic [9:0] CH      = 10'(CELL_H);
  localparam logic [9:0] PITCH_X = 10'(CELL_W + GAP_X);
  localparam logic [9:0] PITCH_Y = 10'(CELL_H + GAP_Y);

  // All region arithmetic stays in 10-bit unsigned; the geometry limits keep it from wrapping.
  function automatic logic [9:0] span_start(input logic [9:0] origin, input logic [9:0] pitch,
                                            input int idx);
    return origin + (10'(idx) * pitch);
  endfunction

  function automatic logic in_span(input logic [9:0] pos, input logic [9:0] start,
                                   input logic [9:0] len);
    return (pos >= start) && (pos < start + len);
  endfunction

`ifdef GRID_BORDER_EN
  function automatic logic on_edge(input logic [9:0] pos, input logic [9:0] start,
                                   input logic [9:0] len);
    return (pos < start + 10'd2) || (pos >= start + len - 10'd2);
  endfunction
`endif

  // ---------------- write port and colour banks ----------------
  rgb_t pending_bank [NUM_CELLS];
  rgb_t active_bank  [NUM_CELLS];
  logic run_q;
  logic bad_q;
  logic commit_pt;
  logic commit;
  logic wr_accept;

  assign commit_pt    = (hcount == 10'd0) && (vcount == COMMIT_LINE);
  // run_q keeps the port closed (and the swap suppressed) until the first edge after reset.
  assign commit       = run_q && commit_pt;
  assign wr_ready     = run_q && !commit_pt;
  assign wr_accept    = wr_valid && wr_ready;
  assign frame_commit = commit;
  assign bad_cell     = bad_q;

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      bad_q <= 1'b0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        pending_bank[i] <= rgb_t'(BG_COLOR);
        active_bank[i]  <= rgb_t'(BG_COLOR);
      end
    end else begin
      run_q <= 1'b1;
      if (commit) begin
        for (int i = 0; i < NUM_CELLS; i++) active_bank[i] <= pending_bank[i];
      end
      // A write never coincides with the swap: wr_ready is low in the commit cycle.
      if (wr_accept) begin
        if (wr_cell < 4'(NUM_CELLS)) pending_bank[wr_cell] <= rgb_t'(wr_color);
        else                         bad_q <= 1'b1;
      end
    end
  end

  // ---------------- region decode ----------------
  logic       in_h, in_v;
  logic       col_hit, row_hit;
  logic [1:0] col, row;
`ifdef GRID_BORDER_EN
  logic       col_edge, row_edge;
`endif

  assign in_h = (hcount >= H_ACT_START) && (hcount <= H_ACT_END);
  assign in_v = (vcount >= V_ACT_START) && (vcount <= V_ACT_END);

  always_comb begin
    col_hit = 1'b0;
    col     = 2'd0;
    row_hit = 1'b0;
    row     = 2'd0;
`ifdef GRID_BORDER_EN
    col_edge = 1'b0;
    row_edge = 1'b0;
`endif
    for (int c = 0; c < GRID_DIM; c++) begin
      if (in_span(hcount, span_start(H_ACT_START, PITCH_X, c), CW)) begin
        col_hit = 1'b1;
        col     = 2'(c);
`ifdef GRID_BORDER_EN
        col_edge = on_edge(hcount, span_start(H_ACT_START, PITCH_X, c), CW);
`endif
      end
    end
    for (int r = 0; r < GRID_DIM; r++) begin
      if (in_span(vcount, span_start(V_ACT_START, PITCH_Y, r), CH)) begin
        row_hit = 1'b1;
        row     = 2'(r);
`ifdef GRID_BORDER_EN
        row_edge = on_edge(vcount, span_start(V_ACT_START, PITCH_Y, r), CH);
`endif
      end
    end
  end

  // ---------------- stage 1: region flags and cell index ----------------
  logic       s1_vis;
  logic       s1_cell;
  logic [3:0] s1_idx;
`ifdef GRID_BORDER_EN
  logic       s1_edge;
`endif

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      s1_vis  <= 1'b0;
      s1_cell <= 1'b0;
      s1_idx  <= 4'd0;
`ifdef GRID_BORDER_EN
      s1_edge <= 1'b0;
`endif
    end else begin
      s1_vis  <= in_h && in_v;
      s1_cell <= col_hit && row_hit;
      s1_idx  <= cell_index(row, col);
`ifdef GRID_BORDER_EN
      s1_edge <= col_edge || row_edge;
`endif
    end
  end

  // ---------------- stage 2: colour lookup ----------------
  rgb_t rgb_q;

  always_ff @(posedge clk_25Mhz or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (!s1_vis) begin
      rgb_q <= '0;
    end else if (s1_cell) begin
`ifdef GRID_BORDER_EN
      rgb_q <= s1_edge ? rgb_t'(24'h000000) : active_bank[s1_idx];
`else
      rgb_q <= active_bank[s1_idx];
`endif
    end else begin
      rgb_q <= rgb_t'(BG_COLOR);
    end
  end

  assign Red   = rgb_q.r;
  assign Green = rgb_q.g;
  assign Blue  = rgb_q.b;

  // ---------------- sync alignment ----------------
  logic [1:0] sync_d;

  vga_delay_line #(
    .WIDTH(2),
    .DEPTH(2)
  ) u_sync_delay (
    .clk_25Mhz(clk_25Mhz),
    .rst      (rst),
    .din      ({hsync_in, vsync_in}),
    .dout     (sync_d)
  );

  assign hsync_out = sync_d[1];
  assign vsync_out = sync_d[0];

endmodule
